// File: rtl/sap1_bist_pkg.sv
// -----------------------------------------------------------------------------
// sap1_bist_pkg
// Shared types and the March C- element table for the RAM BIST sequencer.
//   march_op_e    : the four march operations (write/read of background 0/1)
//   bist_state_e  : sequencer states
//   elem_info()   : direction and operation list of each march element
//   elem_up()     : direction of an element, used to pick its start address
// -----------------------------------------------------------------------------
package sap1_bist_pkg;

   typedef enum logic [1:0] {W0, W1, R0, R1} march_op_e;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

   localparam int NUM_ELEM = 6;
   localparam int ELEM_W   = 3;

   typedef struct packed {
      logic      up;        // 1: address 0..DEPTH-1, 0: DEPTH-1..0
      logic      two_ops;   // element is a read-then-write pair
      march_op_e op0;
      march_op_e op1;
   } march_elem_t;

   // March C-: {up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)}
   function automatic march_elem_t elem_info(input logic [ELEM_W-1:0] idx);
      march_elem_t e;
      case (idx)
         3'd0:    e = '{up: 1'b1, two_ops: 1'b0, op0: W0, op1: W0};
         3'd1:    e = '{up: 1'b1, two_ops: 1'b1, op0: R0, op1: W1};
         3'd2:    e = '{up: 1'b1, two_ops: 1'b1, op0: R1, op1: W0};
         3'd3:    e = '{up: 1'b0, two_ops: 1'b1, op0: R0, op1: W1};
         3'd4:    e = '{up: 1'b0, two_ops: 1'b1, op0: R1, op1: W0};
         default: e = '{up: 1'b1, two_ops: 1'b0, op0: R0, op1: R0};
      endcase
      return e;
   endfunction

   function automatic logic elem_up(input logic [ELEM_W-1:0] idx);
      return (idx != 3'd3) && (idx != 3'd4);
   endfunction

   function automatic logic op_is_write(input march_op_e op);
      return (op == W0) || (op == W1);
   endfunction

   // Operation targets the inverted background
   function automatic logic op_is_one(input march_op_e op);
      return (op == W1) || (op == R1);
   endfunction

endpackage

// File: rtl/bist_cmp.sv
// -----------------------------------------------------------------------------
// bist_cmp
// Registered read-compare stage with first-fail capture.
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : new test accepted; forget previous failure
//   flush        : cancel; drop any read still waiting for its compare
//   rd_issue     : a RAM read is issued this cycle
//   rd_exp/addr/elem : expected data and location of that read
//   rd_data      : RAM read data, valid the cycle after rd_issue
//   mismatch     : compare result this cycle (combinational)
//   fail_seen    : a mismatch has been seen since clear
//   fail_addr/elem : location of the first mismatch
// -----------------------------------------------------------------------------
module bist_cmp
   import sap1_bist_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              flush,
   input  logic              rd_issue,
   input  logic [WIDTH-1:0]  rd_exp,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [ELEM_W-1:0] rd_elem,
   input  logic [WIDTH-1:0]  rd_data,
   output logic              mismatch,
   output logic              fail_seen,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ELEM_W-1:0] fail_elem
);

   logic              pend_q, pend_d;
   logic [WIDTH-1:0]  exp_q, exp_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic [ELEM_W-1:0] cap_elem_q, cap_elem_d;
   logic              seen_q, seen_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [ELEM_W-1:0] felem_q, felem_d;

   assign mismatch = pend_q && (rd_data != exp_q);

   always_comb begin
      pend_d     = rd_issue && !flush;
      exp_d      = rd_issue ? rd_exp  : exp_q;
      cap_addr_d = rd_issue ? rd_addr : cap_addr_q;
      cap_elem_d = rd_issue ? rd_elem : cap_elem_q;
      seen_d     = seen_q;
      faddr_d    = faddr_q;
      felem_d    = felem_q;
      if (clear) begin
         seen_d  = 1'b0;
         faddr_d = '0;
         felem_d = '0;
      end else if (mismatch && !seen_q) begin
         // only the first failure is kept
         seen_d  = 1'b1;
         faddr_d = cap_addr_q;
         felem_d = cap_elem_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q  <= 1'b0;
         seen_q  <= 1'b0;
         faddr_q <= '0;
         felem_q <= '0;
      end else begin
         pend_q  <= pend_d;
         seen_q  <= seen_d;
         faddr_q <= faddr_d;
         felem_q <= felem_d;
      end
   end

   // payload is qualified by pend_q, so it needs no reset
   always_ff @(posedge clk) begin
      exp_q      <= exp_d;
      cap_addr_q <= cap_addr_d;
      cap_elem_q <= cap_elem_d;
   end

   assign fail_seen = seen_q;
   assign fail_addr = faddr_q;
   assign fail_elem = felem_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
// March C- BIST sequencer for the fifo_8x64 RAM BIST port. On start it runs
// the six march elements over every address with one access per cycle,
// compares every read, and reports pass plus the first failing address/element.
//   clk, reset        : clock, asynchronous active-high reset
//   start, abort      : start request (IDLE only), synchronous cancel
//   busy, done, pass  : status; done is a 1-cycle pulse, pass valid from done
//   fail_addr/elem    : first mismatch location
//   bist_en/we/addr/wr_data : RAM BIST access port
//   bist_rd_data      : RAM read data, one cycle after the read access
// -----------------------------------------------------------------------------
module mem_bist_ctrl
   import sap1_bist_pkg::*;
#(
   parameter int               DEPTH        = 8,
   parameter int               WIDTH        = 64,
   parameter int               ADDR_W       = 3,
   parameter logic [WIDTH-1:0] BG_PATTERN   = '0,
   parameter bit               STOP_ON_FAIL = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic              bist_en,
   output logic              bist_we,
   output logic [ADDR_W-1:0] bist_addr,
   output logic [WIDTH-1:0]  bist_wr_data,
   input  logic [WIDTH-1:0]  bist_rd_data
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

   bist_state_e       state_q, state_d;
   logic [ELEM_W-1:0] elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              opi_q, opi_d;     // position inside a read-then-write pair
   logic              pass_q, pass_d;

   march_elem_t       cur;
   march_op_e         op;
   logic [ADDR_W-1:0] last_addr;
   logic              start_ok;
   logic              stop;
   logic              access;
   logic              is_wr;
   logic [WIDTH-1:0]  op_data;
   logic              mismatch;
   logic              fail_seen;

   assign cur       = elem_info(elem_q);
   assign op        = opi_q ? cur.op1 : cur.op0;
   assign last_addr = cur.up ? ADDR_MAX : '0;
   assign start_ok  = (state_q == IDLE) && start && !abort;
   // a mismatch suppresses the access in the same cycle when stopping early
   assign stop      = STOP_ON_FAIL && mismatch;
   assign access    = (state_q == RUN) && !stop;
   assign is_wr     = op_is_write(op);
   assign op_data   = op_is_one(op) ? ~BG_PATTERN : BG_PATTERN;

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      opi_d   = opi_q;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = RUN;
               elem_d  = '0;
               addr_d  = '0;
               opi_d   = 1'b0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = DONE;
            end else if (!cur.two_ops || opi_q) begin
               opi_d = 1'b0;
               if (addr_q == last_addr) begin
                  if (elem_q == LAST_ELEM) begin
                     state_d = DRAIN;
                     elem_d  = '0;
                     addr_d  = '0;
                  end else begin
                     elem_d = elem_q + 3'd1;
                     addr_d = elem_up(elem_q + 3'd1) ? '0 : ADDR_MAX;
                  end
               end else begin
                  addr_d = cur.up ? addr_q + 1'b1 : addr_q - 1'b1;
               end
            end else begin
               opi_d = 1'b1;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;

      // pass is set on entry to DONE so it is already valid with the done pulse
      pass_d = pass_q;
      if (start_ok || abort)
         pass_d = 1'b0;
      else if (state_d == DONE && state_q != DONE)
         pass_d = !(fail_seen || mismatch);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         elem_q  <= '0;
         addr_q  <= '0;
         opi_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         opi_q   <= opi_d;
         pass_q  <= pass_d;
      end
   end

   bist_cmp #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_cmp (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .flush     (abort),
      .rd_issue  (access && !is_wr),
      .rd_exp    (op_data),
      .rd_addr   (addr_q),
      .rd_elem   (elem_q),
      .rd_data   (bist_rd_data),
      .mismatch  (mismatch),
      .fail_seen (fail_seen),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem)
   );

   assign busy         = (state_q == RUN) || (state_q == DRAIN);
   assign done         = (state_q == DONE);
   assign pass         = pass_q;
   assign bist_en      = access;
   assign bist_we      = access && is_wr;
   assign bist_addr    = access ? addr_q : '0;
   assign bist_wr_data = (access && is_wr) ? op_data : '0;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bist_ctrl
// Three sequencer instances run side by side, each with its own RAM model:
//   a: default (background 0, stop on first failure)
//   b: run to completion on failure
//   c: background 64'hAAAA_AAAA_AAAA_AAAA, never faulted
// Fault: bit 13 stuck-at-1 on reads of address 5 (models a and b only).
// Period n = the clock period following the n-th rising edge after start was
// sampled; n=1 is the first access.
// -----------------------------------------------------------------------------
module tb_mem_bist_ctrl;

   localparam logic [63:0] FMASK = 64'h0000_0000_0000_2000;
   localparam logic [63:0] BG_C  = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam int          NLOG  = 200;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic fault_en = 1'b0;

   logic        a_busy, a_done, a_pass, a_en, a_we;
   logic [2:0]  a_fa, a_fe, a_addr;
   logic [63:0] a_wd;
   logic [63:0] a_rd = '0;
   logic        b_busy, b_done, b_pass, b_en, b_we;
   logic [2:0]  b_fa, b_fe, b_addr;
   logic [63:0] b_wd;
   logic [63:0] b_rd = '0;
   logic        c_busy, c_done, c_pass, c_en, c_we;
   logic [2:0]  c_fa, c_fe, c_addr;
   logic [63:0] c_wd;
   logic [63:0] c_rd = '0;

   logic [63:0] mem_a [8];
   logic [63:0] mem_b [8];
   logic [63:0] mem_c [8];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_bist_ctrl u_a (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(a_busy), .done(a_done), .pass(a_pass), .fail_addr(a_fa), .fail_elem(a_fe),
      .bist_en(a_en), .bist_we(a_we), .bist_addr(a_addr), .bist_wr_data(a_wd),
      .bist_rd_data(a_rd)
   );

   mem_bist_ctrl #(.STOP_ON_FAIL(1'b0)) u_b (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(b_busy), .done(b_done), .pass(b_pass), .fail_addr(b_fa), .fail_elem(b_fe),
      .bist_en(b_en), .bist_we(b_we), .bist_addr(b_addr), .bist_wr_data(b_wd),
      .bist_rd_data(b_rd)
   );

   mem_bist_ctrl #(.BG_PATTERN(BG_C)) u_c (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(c_busy), .done(c_done), .pass(c_pass), .fail_addr(c_fa), .fail_elem(c_fe),
      .bist_en(c_en), .bist_we(c_we), .bist_addr(c_addr), .bist_wr_data(c_wd),
      .bist_rd_data(c_rd)
   );

   // RAM models: synchronous write, read data registered one cycle later
   always @(posedge clk) begin
      if (a_en) begin
         if (a_we) mem_a[a_addr] <= a_wd;
         else      a_rd <= mem_a[a_addr] | ((fault_en && a_addr == 3'd5) ? FMASK : 64'h0);
      end
      if (b_en) begin
         if (b_we) mem_b[b_addr] <= b_wd;
         else      b_rd <= mem_b[b_addr] | ((fault_en && b_addr == 3'd5) ? FMASK : 64'h0);
      end
      if (c_en) begin
         if (c_we) mem_c[c_addr] <= c_wd;
         else      c_rd <= mem_c[c_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // results of the last run
   int a_first_done, a_last_done, a_done_cnt, a_acc, a_busy_cnt;
   logic a_pass_d;
   logic [2:0] a_fa_d, a_fe_d;
   int b_first_done, b_done_cnt, b_acc;
   logic b_pass_d;
   logic [2:0] b_fa_d, b_fe_d;
   int c_first_done;
   logic c_pass_d;
   logic        a_en_log   [NLOG];
   logic        a_we_log   [NLOG];
   logic        a_busy_log [NLOG];
   logic [2:0]  a_addr_log [NLOG];
   logic [63:0] a_wd_log   [NLOG];
   logic [63:0] c_wd_log   [NLOG];

   // start pulse, then observe len periods; optional abort / extra start in a given period
   task automatic run(input int len, input int abort_at, input int start_at);
      a_first_done = 0; a_last_done = 0; a_done_cnt = 0; a_acc = 0; a_busy_cnt = 0;
      b_first_done = 0; b_done_cnt = 0; b_acc = 0; c_first_done = 0;
      a_pass_d = 1'bx; b_pass_d = 1'bx; c_pass_d = 1'bx;
      a_fa_d = 'x; a_fe_d = 'x; b_fa_d = 'x; b_fe_d = 'x;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= len; n++) begin
         if (n < NLOG) begin
            a_en_log[n] = a_en; a_we_log[n] = a_we; a_busy_log[n] = a_busy;
            a_addr_log[n] = a_addr; a_wd_log[n] = a_wd; c_wd_log[n] = c_wd;
         end
         if (a_en) a_acc++;
         if (a_busy) a_busy_cnt++;
         if (b_en) b_acc++;
         if (a_done) begin
            a_done_cnt++;
            a_last_done = n;
            if (a_first_done == 0) begin
               a_first_done = n; a_pass_d = a_pass; a_fa_d = a_fa; a_fe_d = a_fe;
            end
         end
         if (b_done) begin
            b_done_cnt++;
            if (b_first_done == 0) begin
               b_first_done = n; b_pass_d = b_pass; b_fa_d = b_fa; b_fe_d = b_fe;
            end
         end
         if (c_done && c_first_done == 0) begin
            c_first_done = n; c_pass_d = c_pass;
         end
         abort = (n == abort_at);
         start = (n == start_at);
         @(posedge clk);
         #1;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   typedef struct {
      bit fault;
      int a_done, a_busy, a_acc; bit a_pass; int a_fa, a_fe;
      int b_done, b_acc;         bit b_pass; int b_fa, b_fe;
      int c_done;                bit c_pass;
   } row_t;

   row_t rows [2];

   initial begin
      // row 0: bit-13 fault at addr 5 -> first read of addr 5 in E1 is access 19
      rows[0] = '{fault: 1'b1, a_done: 21, a_busy: 20, a_acc: 19, a_pass: 1'b0, a_fa: 5, a_fe: 1,
                  b_done: 82, b_acc: 80, b_pass: 1'b0, b_fa: 5, b_fe: 1, c_done: 82, c_pass: 1'b1};
      // row 1: fault-free, full 80-access test everywhere
      rows[1] = '{fault: 1'b0, a_done: 82, a_busy: 81, a_acc: 80, a_pass: 1'b1, a_fa: 0, a_fe: 0,
                  b_done: 82, b_acc: 80, b_pass: 1'b1, b_fa: 0, b_fe: 0, c_done: 82, c_pass: 1'b1};

      #2;
      chk("rst_busy", a_busy, 0);  chk("rst_done", a_done, 0); chk("rst_pass", a_pass, 0);
      chk("rst_en", a_en, 0);      chk("rst_we", a_we, 0);     chk("rst_addr", a_addr, 0);
      chk("rst_wd", a_wd, 0);      chk("rst_fa", a_fa, 0);     chk("rst_fe", a_fe, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int r = 0; r < 2; r++) begin
         fault_en = rows[r].fault;
         run(90, 0, 0);
         chk($sformatf("r%0d_a_done_at", r), a_first_done, rows[r].a_done);
         chk($sformatf("r%0d_a_done_cnt", r), a_done_cnt, 1);
         chk($sformatf("r%0d_a_busy", r), a_busy_cnt, rows[r].a_busy);
         chk($sformatf("r%0d_a_acc", r), a_acc, rows[r].a_acc);
         chk($sformatf("r%0d_a_pass", r), a_pass_d, rows[r].a_pass);
         chk($sformatf("r%0d_a_fa", r), a_fa_d, rows[r].a_fa);
         chk($sformatf("r%0d_a_fe", r), a_fe_d, rows[r].a_fe);
         chk($sformatf("r%0d_b_done_at", r), b_first_done, rows[r].b_done);
         chk($sformatf("r%0d_b_acc", r), b_acc, rows[r].b_acc);
         chk($sformatf("r%0d_b_pass", r), b_pass_d, rows[r].b_pass);
         chk($sformatf("r%0d_b_fa", r), b_fa_d, rows[r].b_fa);
         chk($sformatf("r%0d_b_fe", r), b_fe_d, rows[r].b_fe);
         chk($sformatf("r%0d_c_done_at", r), c_first_done, rows[r].c_done);
         chk($sformatf("r%0d_c_pass", r), c_pass_d, rows[r].c_pass);
      end
      fault_en = 1'b0;

      // access order of the clean run: E0 writes 0 to 0..7 in periods 1..8
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("e0_we_%0d", i), {a_en_log[i+1], a_we_log[i+1]}, 2'b11);
         chk($sformatf("e0_addr_%0d", i), a_addr_log[i+1], i);
         chk($sformatf("e0_wd_%0d", i), a_wd_log[i+1], 64'h0);
      end
      // E3 starts at access 41: read addr 7-j then write ones to it
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("e3_rd_%0d", j), {a_en_log[41+2*j], a_we_log[41+2*j], a_addr_log[41+2*j]},
             {2'b10, 3'(7-j)});
         chk($sformatf("e3_wr_%0d", j), {a_we_log[42+2*j], a_addr_log[42+2*j]}, {1'b1, 3'(7-j)});
         chk($sformatf("e3_wd_%0d", j), a_wd_log[42+2*j], 64'hFFFF_FFFF_FFFF_FFFF);
      end
      chk("busy_p81", a_busy_log[81], 1'b1);
      chk("en_p81", a_en_log[81], 1'b0);
      chk("busy_p82", a_busy_log[82], 1'b0);
      // alternate background: E0 writes AAAA.., E1 writes 5555..
      chk("bg_e0_wd", c_wd_log[1], BG_C);
      for (int a = 0; a < 8; a++)
         chk($sformatf("bg_e1_wd_%0d", a), c_wd_log[10+2*a], 64'h5555_5555_5555_5555);

      // abort during access 40
      run(90, 40, 0);
      chk("abort_en_p40", a_en_log[40], 1'b1);
      chk("abort_busy_p41", a_busy_log[41], 1'b0);
      chk("abort_en_p41", a_en_log[41], 1'b0);
      chk("abort_no_done", a_done_cnt, 0);
      chk("abort_pass", a_pass, 1'b0);
      chk("abort_b_no_done", b_done_cnt, 0);
      run(90, 0, 0);
      chk("post_abort_done_at", a_first_done, 82);
      chk("post_abort_pass", a_pass_d, 1'b1);

      // start while busy is ignored
      run(90, 0, 30);
      chk("busy_start_done_at", a_first_done, 82);
      chk("busy_start_done_cnt", a_done_cnt, 1);
      chk("busy_start_acc", a_acc, 80);

      // new start in the first idle period after done
      run(170, 0, 83);
      chk("b2b_done_cnt", a_done_cnt, 2);
      chk("b2b_second_done_at", a_last_done, 165);
      chk("b2b_pass", a_pass, 1'b1);

      // asynchronous reset in period 30 (inside E2), between clock edges
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (29) @(posedge clk);
      #2;
      chk("pre_rst_en", a_en, 1'b1);
      chk("pre_rst_addr", a_addr, 3'd2);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", a_busy, 0); chk("mid_rst_en", a_en, 0);
      chk("mid_rst_we", a_we, 0);     chk("mid_rst_addr", a_addr, 0);
      chk("mid_rst_wd", a_wd, 0);     chk("mid_rst_done", a_done, 0);
      chk("mid_rst_pass", a_pass, 0); chk("mid_rst_c_busy", c_busy, 0);
      @(negedge clk);
      reset = 1'b0;
      run(90, 0, 0);
      chk("post_rst_done_at", a_first_done, 82);
      chk("post_rst_pass", a_pass_d, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
